// File: rtl/boot_seq_ctrl_if.sv
// boot_seq_if: start/mask/channel handshake and boot status bundle for boot_seq_ctrl
interface boot_seq_if #(
  parameter int N_CH      = 3,
  parameter int MAX_RETRY = 2
);
  logic                           start_i;
  logic [N_CH-1:0]                ch_en_i;
  logic [N_CH-1:0]                ch_done_i;
  logic [N_CH-1:0]                ch_err_i;
  logic                           s_rst_n;
  logic                           fetch_enable;
  logic [N_CH-1:0]                ch_start_o;
  logic                           busy_o;
  logic                           done_o;
  logic                           fail_o;
  logic [$clog2(N_CH):0]          fail_ch_o;
  logic [$clog2(MAX_RETRY+1):0]   retry_o;
  modport slave (
    input  start_i, ch_en_i, ch_done_i, ch_err_i,
    output s_rst_n, fetch_enable, ch_start_o, busy_o, done_o, fail_o, fail_ch_o, retry_o
  );
  modport master (
    output start_i, ch_en_i, ch_done_i, ch_err_i,
    input  s_rst_n, fetch_enable, ch_start_o, busy_o, done_o, fail_o, fail_ch_o, retry_o
  );
endinterface

// File: rtl/boot_seq_ctrl.sv
// boot_seq_ctrl: holds the core in reset, runs masked loader channels in order with watchdog and retry
module boot_seq_ctrl #(
  parameter int N_CH       = 3,
  parameter int RST_CYCLES = 10,
  parameter int GAP_CYCLES = 10,
  parameter int TIMEOUT    = 4096,
  parameter int MAX_RETRY  = 2,
  parameter int AUTO_START = 1
) (
  input  logic       s_clk,
  input  logic       rst_n,
  boot_seq_if.slave  bus
);
  localparam int IW    = $clog2(N_CH) + 1;
  localparam int RW    = $clog2(MAX_RETRY + 1) + 1;
  localparam int MAXC  = (RST_CYCLES > GAP_CYCLES) ?
                         ((RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT) :
                         ((GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT);
  localparam int CW    = $clog2(MAXC + 1);
  localparam int TO_M1 = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [2:0] {HALT, RST_HOLD, SETTLE, LOAD, GAP, FETCH, FAIL} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]   ch_q, ch_d, fail_ch_q, fail_ch_d;
  logic [N_CH-1:0] mask_q, mask_d, start_q, start_d, sel;
  logic [RW-1:0]   retry_q, retry_d;
  logic            s_rst_n_q, s_rst_n_d, fetch_q, fetch_d, busy_q, busy_d;
  logic            done_q, done_d, fail_q, fail_d;
  logic            first_ok, next_ok, fail_now, done_now;
  logic [IW-1:0]   first_idx, next_idx;

  // Lowest enabled channel overall and lowest enabled channel above the current one
  always_comb begin
    first_ok  = 1'b0;
    first_idx = '0;
    next_ok   = 1'b0;
    next_idx  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        first_ok  = 1'b1;
        first_idx = IW'(i);
      end
      if (mask_q[i] && IW'(i) > ch_q) begin
        next_ok  = 1'b1;
        next_idx = IW'(i);
      end
    end
  end

  assign sel      = N_CH'(1) << ch_q;
  assign cnt_inc  = (cnt_q == CW'(MAXC)) ? cnt_q : cnt_q + CW'(1);
  assign fail_now = (|(bus.ch_err_i & sel)) || (TIMEOUT != 0 && cnt_q == CW'(TO_M1));
  assign done_now = |(bus.ch_done_i & sel);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    ch_d      = ch_q;
    mask_d    = mask_q;
    retry_d   = retry_q;
    fail_ch_d = fail_ch_q;
    case (state_q)
      HALT: if (AUTO_START != 0 || bus.start_i) begin
        state_d = RST_HOLD;
        mask_d  = bus.ch_en_i;
        cnt_d   = '0;
      end
      RST_HOLD: if (cnt_q == CW'(RST_CYCLES - 1)) begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: if (cnt_q == CW'(GAP_CYCLES - 1)) begin
        state_d = first_ok ? LOAD : FETCH;
        ch_d    = first_idx;
        cnt_d   = '0;
      end
      LOAD: if (fail_now) begin
        fail_ch_d = ch_q;
        cnt_d     = '0;
        state_d   = (retry_q < RW'(MAX_RETRY)) ? RST_HOLD : FAIL;
        retry_d   = (retry_q < RW'(MAX_RETRY)) ? retry_q + RW'(1) : retry_q;
      end else if (done_now) begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: if (cnt_q == CW'(GAP_CYCLES - 1)) begin
        state_d = next_ok ? LOAD : FETCH;
        ch_d    = next_ok ? next_idx : ch_q;
        cnt_d   = '0;
      end
      default: ;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_comb begin
    s_rst_n_d = state_d inside {SETTLE, LOAD, GAP, FETCH};
    fetch_d   = state_d == FETCH;
    done_d    = state_d == FETCH;
    fail_d    = state_d == FAIL;
    busy_d    = !(state_d inside {HALT, FETCH, FAIL});
    start_d   = (state_d == LOAD) ? N_CH'(1) << ch_d : '0;
  end

  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HALT;
      cnt_q     <= '0;
      ch_q      <= '0;
      mask_q    <= '0;
      retry_q   <= '0;
      fail_ch_q <= '0;
      s_rst_n_q <= 1'b0;
      fetch_q   <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      mask_q    <= mask_d;
      retry_q   <= retry_d;
      fail_ch_q <= fail_ch_d;
      s_rst_n_q <= s_rst_n_d;
      fetch_q   <= fetch_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
    end
  end

  assign bus.s_rst_n      = s_rst_n_q;
  assign bus.fetch_enable = fetch_q;
  assign bus.ch_start_o   = start_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.fail_o       = fail_q;
  assign bus.fail_ch_o    = fail_ch_q;
  assign bus.retry_o      = retry_q;
endmodule

// File: tb/tb_boot_seq_ctrl.sv
// tb_boot_seq_ctrl: timeline model of each boot run feeds a scoreboard checked on every output change
module tb_boot_seq_ctrl;
  localparam int R  = 10;
  localparam int G  = 10;
  localparam int TO = 16;
  localparam int MR = 2;

  typedef struct packed {
    logic [2:0] st;
    logic       rn, fe, busy, dn, fl;
    logic [2:0] fc, rt;
  } snap_t;
  typedef struct {
    int    cyc;
    snap_t s;
  } ev_t;

  logic  s_clk, rst_n;
  int    cyc, tests, fails;
  bit    armed;
  ev_t   exp_q[$];
  int    kind[3][3];
  int    dly[3][3];

  boot_seq_if #(.N_CH(3), .MAX_RETRY(MR)) bus();

  boot_seq_ctrl #(
    .N_CH(3), .RST_CYCLES(R), .GAP_CYCLES(G), .TIMEOUT(TO), .MAX_RETRY(MR), .AUTO_START(1)
  ) dut (
    .s_clk(s_clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  always @(posedge s_clk or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;

  function automatic snap_t get_snap();
    return snap_t'({bus.ch_start_o, bus.s_rst_n, bus.fetch_enable, bus.busy_o,
                    bus.done_o, bus.fail_o, bus.fail_ch_o, bus.retry_o});
  endfunction

  task automatic push(input int t, input snap_t s);
    ev_t e;
    e.cyc = t;
    e.s   = s;
    exp_q.push_back(e);
  endtask

  // kind: 0 done after d cycles, 1 err after d, 2 done+err after d, 3 never answers
  task automatic model(input logic [2:0] m);
    snap_t s;
    int t, a, e;
    bit fin, failed, fl;
    s = '0; t = 1; a = 0; fin = 0;
    s.busy = 1'b1;
    push(t, s);
    while (!fin) begin
      t += R;
      s.rn = 1'b1;
      push(t, s);
      t += G;
      failed = 0;
      for (int k = 0; k < 3; k++) begin
        if (m[k] && !failed) begin
          s.st = 3'(1 << k);
          push(t, s);
          fl = kind[a][k] != 0 || dly[a][k] >= TO;
          e  = (kind[a][k] == 3) ? TO : (dly[a][k] < TO ? dly[a][k] : TO);
          t += e;
          s.st = '0;
          if (fl) begin
            failed = 1;
            s.fc = 3'(k);
            s.rn = 1'b0;
            if (a < MR) begin
              a++;
              s.rt = 3'(a);
              push(t, s);
            end else begin
              s.busy = 1'b0;
              s.fl   = 1'b1;
              push(t, s);
              fin = 1;
            end
          end else begin
            push(t, s);
            t += G;
          end
        end
      end
      if (!failed) begin
        s.fe = 1'b1; s.dn = 1'b1; s.busy = 1'b0;
        push(t, s);
        fin = 1;
      end
    end
  endtask

  initial begin
    snap_t cur, prev;
    ev_t e;
    prev = '0;
    forever begin
      @(negedge s_clk);
      cur = get_snap();
      if (armed && cur != prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.s != cur || e.cyc != cyc) begin
            fails++;
            $display("FAIL event cyc got=%0d exp=%0d outputs got=%h exp=%h", cyc, e.cyc, cur, e.s);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    logic [2:0] act, pact, nd, ne;
    int el, k, a;
    el = 0; pact = '0;
    bus.ch_done_i = '0;
    bus.ch_err_i  = '0;
    forever begin
      @(negedge s_clk);
      act  = bus.ch_start_o;
      el   = (act == 0) ? 0 : (act == pact ? el + 1 : 1);
      pact = act;
      nd   = 3'($urandom) & 3'($urandom) & ~act;
      ne   = 3'($urandom) & 3'($urandom) & 3'($urandom) & ~act;
      if (act != 0) begin
        k = act[1] ? 1 : (act[2] ? 2 : 0);
        a = (bus.retry_o > 3'(MR)) ? MR : int'(bus.retry_o);
        if ((kind[a][k] == 0 || kind[a][k] == 2) && el >= dly[a][k]) nd[k] = 1'b1;
        if ((kind[a][k] == 1 || kind[a][k] == 2) && el == dly[a][k]) ne[k] = 1'b1;
      end
      bus.ch_done_i = nd;
      bus.ch_err_i  = ne;
    end
  end

  task automatic set_all(input int kd, input int d);
    for (int a = 0; a < 3; a++)
      for (int k = 0; k < 3; k++) begin
        kind[a][k] = kd;
        dly[a][k]  = d;
      end
  endtask

  task automatic run(input logic [2:0] m, input bit abort);
    int n;
    armed = 0;
    rst_n = 1'b0;
    exp_q.delete();
    bus.ch_en_i = m;
    repeat (3) @(negedge s_clk);
    tests++;
    if (get_snap() != '0) begin
      fails++;
      $display("FAIL reset_state got=%h exp=0", get_snap());
    end
    model(m);
    armed = 1;
    rst_n = 1'b1;
    n = 0;
    while (n < 3000 && !(abort ? bus.ch_start_o == 3'b010 : exp_q.size() == 0)) begin
      @(negedge s_clk);
      n++;
      if (n == 2) bus.ch_en_i = 3'($urandom);
      bus.start_i = 1'($urandom);
    end
    if (n >= 3000) begin
      tests++;
      fails++;
      $display("FAIL run_timeout mask=%b pending=%0d exp=0", m, exp_q.size());
    end
    if (abort) begin
      armed = 0;
      rst_n = 1'b0;
      #1;
      tests++;
      if (get_snap() != '0) begin
        fails++;
        $display("FAIL midrun_reset got=%h exp=0", get_snap());
      end
    end else begin
      repeat (20) @(negedge s_clk);
      armed = 0;
    end
  endtask

  initial begin
    int r;
    tests = 0; fails = 0; armed = 0;
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.ch_en_i = '0;
    set_all(0, 5);
    run(3'b111, 0);
    run(3'b101, 0);
    run(3'b000, 0);
    kind[0][1] = 1; dly[0][1] = 3;
    run(3'b111, 0);
    set_all(0, 5);
    for (int a = 0; a < 3; a++) kind[a][2] = 3;
    run(3'b111, 0);
    set_all(0, 4);
    kind[0][0] = 2; dly[0][0] = 8;
    run(3'b111, 0);
    set_all(0, 5);
    run(3'b111, 1);
    run(3'b111, 0);
    for (int i = 0; i < 25; i++) begin
      for (int a = 0; a < 3; a++)
        for (int k = 0; k < 3; k++) begin
          r = int'($urandom_range(0, 5));
          kind[a][k] = (r <= 2) ? 0 : r - 2;
          dly[a][k]  = int'($urandom_range(1, 18));
        end
      run(3'($urandom), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
